// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC, req/ack instruction-memory port and IR feeding the decoder.
// Define IFETCH_MISALIGN_CHK_EN to flag misaligned redirect targets on misaligned_out.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_rdata_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        instr_valid_out,
  output logic [6:0]  opcode_out,
  output logic [2:0]  func_3_out,
  output logic        func_7_5_out,
  output logic        misaligned_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        req;
  logic        capture;

  // A valid IR under stall is the only thing that can be held, so only then is fetch paused.
  always_comb begin
    req     = (state_q == S_REQ) && !flush_in && !(stall_in && valid_q);
    capture = req && imem_ack_in;
  end

  always_comb begin
    state_d  = S_REQ;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (flush_in) begin
      pc_d    = redirect_pc_in & ~32'h0000_0003;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (capture) begin
      instr_d  = imem_rdata_in;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      pc_d     = pc_q + 32'd4;
    end else if (req) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pc_out_q <= RESET_PC;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  logic misaligned_q, misaligned_d;

  always_comb begin
    misaligned_d = flush_in && (redirect_pc_in[1:0] != 2'b00);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned_out = misaligned_q;
`else
  assign misaligned_out = 1'b0;
`endif

  assign imem_req_out    = req;
  assign imem_addr_out   = pc_q;
  assign instr_out       = instr_q;
  assign pc_out          = pc_out_q;
  assign instr_valid_out = valid_q;
  assign opcode_out      = instr_q[6:0];
  assign func_3_out      = instr_q[14:12];
  assign func_7_5_out    = instr_q[30];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed steps plus random traffic vs. a cycle model.
module tb_instr_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, ack, ack2;
  logic [31:0] rpc, rdata, rdata2;

  logic        req, valid, f75, mis;
  logic [31:0] addr, instr, pco;
  logic [6:0]  opc;
  logic [2:0]  f3;

  logic        req2, valid2, f75_2, mis2;
  logic [31:0] addr2, instr2, pco2;
  logic [6:0]  opc2;
  logic [2:0]  f3_2;

  always #5 clk = ~clk;

  instr_fetch_stage dut (
    .clk_in(clk), .rst_in(rst), .stall_in(stall), .flush_in(flush),
    .redirect_pc_in(rpc), .imem_req_out(req), .imem_addr_out(addr),
    .imem_ack_in(ack), .imem_rdata_in(rdata), .instr_out(instr), .pc_out(pco),
    .instr_valid_out(valid), .opcode_out(opc), .func_3_out(f3),
    .func_7_5_out(f75), .misaligned_out(mis)
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_in(clk), .rst_in(rst), .stall_in(1'b0), .flush_in(1'b0),
    .redirect_pc_in(32'h0), .imem_req_out(req2), .imem_addr_out(addr2),
    .imem_ack_in(ack2), .imem_rdata_in(rdata2), .instr_out(instr2), .pc_out(pco2),
    .instr_valid_out(valid2), .opcode_out(opc2), .func_3_out(f3_2),
    .func_7_5_out(f75_2), .misaligned_out(mis2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural view of the stage (PC, IR slot, start flag).
  logic [31:0] m_pc, m_ir, m_pcout;
  logic        m_valid, m_started, m_mis;
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ir = NOP; m_pcout = 32'h0;
    m_valid = 1'b0; m_started = 1'b0; m_mis = 1'b0;
  endtask

  // One clock: drive inputs at negedge, check all outputs, then advance the model at posedge.
  task automatic step(input logic s, input logic f, input logic [31:0] rp,
                      input logic a, input logic r, input string tag);
    logic exp_req;
    logic [31:0] fetched;
    @(negedge clk);
    stall = s; flush = f; rpc = rp; ack = a; rst = r;
    rdata = word_at(m_pc);
    fetched = rdata;
    #1;
    exp_req = m_started && !f && !(s && m_valid);
    chk({tag, ".req"},    {31'd0, req},   {31'd0, exp_req});
    chk({tag, ".addr"},   addr,           m_pc);
    chk({tag, ".instr"},  instr,          m_ir);
    chk({tag, ".pc_out"}, pco,            m_pcout);
    chk({tag, ".valid"},  {31'd0, valid}, {31'd0, m_valid});
    chk({tag, ".opcode"}, {25'd0, opc},   {25'd0, m_ir[6:0]});
    chk({tag, ".func3"},  {29'd0, f3},    {29'd0, m_ir[14:12]});
    chk({tag, ".func7_5"},{31'd0, f75},   {31'd0, m_ir[30]});
    chk({tag, ".misalign"},{31'd0, mis},  {31'd0, m_mis});
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (f) begin
        m_pc = rp & ~32'h3; m_valid = 1'b0; m_ir = NOP;
      end else if (exp_req && a) begin
        m_ir = fetched; m_pcout = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else if (exp_req) begin
        m_valid = 1'b0; m_ir = NOP;
      end
`ifdef IFETCH_MISALIGN_CHK_EN
      m_mis = f && (rp[1:0] != 2'b00);
`else
      m_mis = 1'b0;
`endif
      m_started = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; ack = 1'b0; rpc = 32'h0; rdata = 32'h0;
    ack2 = 1'b0; rdata2 = 32'h0;
    mem[32'h0] = 32'h0050_0093;
    mem[32'h4] = 32'h00A0_0113;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset release, ack every cycle
    step(0, 0, 0, 1, 0, "t1_idle");
    step(0, 0, 0, 1, 0, "t1_f0");
    step(0, 0, 0, 1, 0, "t1_f4");
    // Ack withheld at pc 0x8
    repeat (3) step(0, 0, 0, 0, 0, "t2_wait");
    step(0, 0, 0, 1, 0, "t2_ack");
    step(0, 0, 0, 1, 0, "t2_next");
    step(0, 0, 0, 1, 0, "t2_pc10");
    // Stall with valid IR at pc 0x10
    repeat (4) step(1, 0, 0, 1, 0, "t3_stall");
    repeat (3) step(0, 0, 0, 1, 0, "t3_resume");
    // Flush during stall with same-cycle ack
    step(1, 1, 32'h100, 1, 0, "t4_flush");
    step(1, 0, 0, 1, 0, "t4_after");
    step(0, 0, 0, 1, 0, "t4_run");
    // Misaligned redirect
    step(0, 1, 32'h102, 1, 0, "t6_flush");
    step(0, 0, 0, 1, 0, "t6_mis");
    step(0, 0, 0, 1, 0, "t6_clear");
    // Reset mid-stall with ack pending
    step(1, 0, 0, 1, 0, "t6_stall");
    step(1, 0, 0, 1, 1, "t6_rst");
    step(1, 0, 0, 1, 0, "t6_post");
    step(0, 0, 0, 1, 0, "t6_run");

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0, "rnd");
    end
    repeat (2) step(0, 0, 0, 1, 0, "tail");

    // Wrap-around instance: PC starts at 0xFFFF_FFFC
    @(negedge clk);
    chk("t5.addr_pre", addr2, 32'hFFFF_FFFC);
    chk("t5.req_pre", {31'd0, req2}, 32'd1);
    ack2 = 1'b1; rdata2 = 32'h0000_0513;
    @(posedge clk);
    @(negedge clk);
    ack2 = 1'b0;
    #1;
    chk("t5.addr_wrap", addr2, 32'h0000_0000);
    chk("t5.pc_out", pco2, 32'hFFFF_FFFC);
    chk("t5.instr", instr2, 32'h0000_0513);
    chk("t5.valid", {31'd0, valid2}, 32'd1);
    chk("t5.misalign", {31'd0, mis2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
